// File: rtl/decoder_2_to_4_if.sv
// Select/enable bundle for the registered 2-to-4 decoder.
// master drives en/in and observes out/valid; slave is the decoder side.
interface decoder_2_to_4_if;
  logic       en;
  logic [1:0] in;
  logic [3:0] out;
  logic       valid;

  modport master (
    output en,
    output in,
    input  out,
    input  valid
  );

  modport slave (
    input  en,
    input  in,
    output out,
    output valid
  );
endinterface

// File: rtl/decoder_2_to_4.sv
// Registered 2-to-4 line decoder: one-hot (or one-cold) output one clock
// after the select is sampled, gated by enable, cleared by synchronous reset.
module decoder_2_to_4 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input logic              clk,
  input logic              rst,
  decoder_2_to_4_if.slave  bus
);

  localparam logic [3:0] OUT_IDLE = OUT_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [3:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic [3:0] dec;

  // Next-state: decode the select when enabled, otherwise all lines deasserted.
  always_comb begin
    dec          = '0;
    dec[bus.in]  = 1'b1;
    valid_d      = bus.en;
    out_d        = bus.en ? dec : '0;
    if (OUT_ACTIVE_LOW) begin
      out_d = ~out_d;
    end
  end

  // Output registers; reset overrides enable and select.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= OUT_IDLE;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_decoder_2_to_4.sv
// Scoreboard bench for decoder_2_to_4: active-high and active-low builds
// driven with identical stimulus, compared against a one-cycle reference.
module tb_decoder_2_to_4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decoder_2_to_4_if bus_hi ();
  decoder_2_to_4_if bus_lo ();

  decoder_2_to_4 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi.slave)
  );

  decoder_2_to_4 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk (clk),
    .rst (rst),
    .bus (bus_lo.slave)
  );

  typedef struct {
    logic [3:0] out;    // active-high form
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: after the edge, the line numbered by the select is asserted
  // only when not in reset and enabled.
  function automatic exp_t model(input logic r, input logic e, input logic [1:0] sel);
    exp_t x;
    int unsigned idx;
    idx     = sel;
    x.valid = !r && e;
    x.out   = x.valid ? 4'(2 ** idx) : 4'd0;
    return x;
  endfunction

  task automatic drive(input logic r, input logic e, input logic [1:0] sel);
    @(negedge clk);
    rst       = r;
    bus_hi.en = e;
    bus_hi.in = sel;
    bus_lo.en = e;
    bus_lo.in = sel;
    if (e && $isunknown(sel)) begin
      errors++;
      $display("FAIL x_on_in: in=%b while en=1", sel);
    end
    exp_q.push_back(model(r, e, sel));
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare one expectation per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check4("out_hi",   bus_hi.out,   e.out);
      check1("valid_hi", bus_hi.valid, e.valid);
      check4("out_lo",   bus_lo.out,   ~e.out);
      check1("valid_lo", bus_lo.valid, e.valid);
      checks++;
      if ($countones(bus_hi.out) != (bus_hi.valid ? 1 : 0)) begin
        errors++;
        $display("FAIL onehot_hi: out=%b valid=%b", bus_hi.out, bus_hi.valid);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bus_hi.en = 1'b0;
    bus_hi.in = 2'b00;
    bus_lo.en = 1'b0;
    bus_lo.in = 2'b00;

    // Reset held with en=1, in=11, then release.
    drive(1'b1, 1'b1, 2'b11);
    drive(1'b1, 1'b1, 2'b11);
    drive(1'b0, 1'b1, 2'b11);

    // Full sweep.
    for (int unsigned i = 0; i < 4; i++) drive(1'b0, 1'b1, 2'(i));

    // Enable gating at in=10.
    drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b0, 2'b10);
    drive(1'b0, 1'b1, 2'b10);

    // Reset mid-stream at in=01, sweep resumes.
    drive(1'b0, 1'b1, 2'b00);
    drive(1'b1, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b1, 2'b11);

    // Random traffic.
    for (int unsigned i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int unsigned i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
